stream_mux_rr: RTL and testbench

- Parametrised N-bit, CHANNELS-way stream multiplexer with valid/ready handshakes on every input and on the output.
- Two grant modes: fixed select (s port, same semantics as the combinational mux tree) and round-robin arbitration.
- One registered output stage gives 1-cycle latency and full throughput.
- Sits between multiple producers (e.g. register-file read ports, bus masters) and a single consumer.

---
 rtl/stream_mux_rr.sv | 102 ++++++++++
 tb/tb_stream_mux_rr.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: CHANNELS-way valid/ready stream mux with fixed-select or round-robin grant,
// single registered output stage. Optional transfer counter under STREAM_MUX_XFER_COUNT_EN.
module stream_mux_rr #(
    parameter int N        = 32,
    parameter int CHANNELS = 32,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      s,
    output logic [N-1:0]          out_data,
    output logic [SEL_W-1:0]      out_chan,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef STREAM_MUX_XFER_COUNT_EN
    ,
    output logic [31:0]           xfer_count
`endif
);

    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CHANNELS - 1);

    logic [N-1:0]     chan_data [CHANNELS];
    logic [SEL_W-1:0] ptr;
    logic             can_accept;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer;
    int unsigned      rr_idx;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign chan_data[gi] = in_data[gi*N +: N];
    end

    assign can_accept = !out_valid || out_ready;

    // Round-robin scans pointer+1 .. pointer+CHANNELS, wrapping; the first valid channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        if (!mode) begin
            if (32'(s) < CHANNELS && in_valid[s]) begin
                grant_vld = 1'b1;
                grant_idx = s;
            end
        end else begin
            for (int unsigned k = 1; k <= CHANNELS; k++) begin
                rr_idx = 32'(ptr) + k;
                if (rr_idx >= CHANNELS) begin
                    rr_idx = rr_idx - CHANNELS;
                end
                if (!grant_vld && in_valid[SEL_W'(rr_idx)]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            in_ready[i] = !rst && can_accept && grant_vld && (SEL_W'(i) == grant_idx);
        end
    end

    assign xfer = !rst && can_accept && grant_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= PTR_RST;
        end else if (xfer) begin
            out_data  <= chan_data[grant_idx];
            out_chan  <= grant_idx;
            out_valid <= 1'b1;
            if (mode) begin
                ptr <= grant_idx;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_XFER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr: a 32x32 instance for the main function
// and a 5-channel instance for the out-of-range select case.
module tb_stream_mux_rr;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] in_data;
    logic [31:0]   in_valid;
    logic [31:0]   in_ready;
    logic          mode;
    logic [4:0]    s;
    logic [31:0]   out_data;
    logic [4:0]    out_chan;
    logic          out_valid;
    logic          out_ready;
`ifdef STREAM_MUX_XFER_COUNT_EN
    logic [31:0]   xfer_count;
`endif

    logic [39:0]   in_data5;
    logic [4:0]    in_valid5;
    logic [4:0]    in_ready5;
    logic          mode5;
    logic [2:0]    s5;
    logic [7:0]    out_data5;
    logic [2:0]    out_chan5;
    logic          out_valid5;
    logic          out_ready5;
`ifdef STREAM_MUX_XFER_COUNT_EN
    logic [31:0]   xfer_count5;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(32), .CHANNELS(32)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .s(s), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef STREAM_MUX_XFER_COUNT_EN
        , .xfer_count(xfer_count)
`endif
    );

    stream_mux_rr #(.N(8), .CHANNELS(5)) dut5 (
        .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .mode(mode5), .s(s5), .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
        .out_ready(out_ready5)
`ifdef STREAM_MUX_XFER_COUNT_EN
        , .xfer_count(xfer_count5)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_index_data();
        for (int i = 0; i < 32; i++) in_data[i*32 +: 32] = 32'(i);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; s = 5'd5; in_valid = '1; out_ready = 1'b1;
        fill_index_data();
        mode5 = 1'b0; s5 = 3'd7; in_valid5 = '0; out_ready5 = 1'b1;
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'hA0 + 8'(i);
        tick();
        tick();
        check("rst_in_ready", in_ready, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'h0);
`ifdef STREAM_MUX_XFER_COUNT_EN
        check("rst_xfer_count", xfer_count, 32'h0);
`endif

        // 5-channel instance: s=7 is out of range and must never grant
        rst = 1'b0; in_valid = '0; in_valid5 = '1;
        #1;
        check("s7_in_ready", 32'(in_ready5), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("s7_out_valid", 32'(out_valid5), 32'h0);
        end
        s5 = 3'd4;
        #1;
        check("s4_in_ready", 32'(in_ready5), 32'h10);
        tick();
        check("s4_out_chan", 32'(out_chan5), 32'd4);
        check("s4_out_data", 32'(out_data5), 32'hA4);
        in_valid5 = '0;

        // Fixed select, s=5
        in_data[5*32 +: 32] = 32'hDEADBEEF;
        in_valid = '1; mode = 1'b0; s = 5'd5;
        #1;
        check("fix_in_ready", in_ready, 32'h0000_0020);
        tick();
        check("fix_out_data", out_data, 32'hDEADBEEF);
        check("fix_out_chan", 32'(out_chan), 32'd5);
        check("fix_out_valid", 32'(out_valid), 32'd1);
        in_valid = '0;
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_out_data", out_data, 32'hDEADBEEF);

        // Round-robin, all valid; pointer still at 31 so the first grant is channel 0
        fill_index_data();
        in_valid = '1; mode = 1'b1;
        for (int c = 0; c < 34; c++) begin
            #1;
            check("rr_in_ready", in_ready, 32'h1 << (c % 32));
            tick();
            check("rr_out_chan", 32'(out_chan), 32'(c % 32));
            check("rr_out_data", out_data, 32'(c % 32));
            check("rr_out_valid", 32'(out_valid), 32'd1);
        end

        // Sparse: pointer at 1, channels 3 and 30 alternate
        in_valid = (32'h1 << 3) | (32'h1 << 30);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("sparse_out_chan", 32'(out_chan), (c % 2 == 0) ? 32'd3 : 32'd30);
        end

        // Backpressure with channel 30 held
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("stall_in_ready", in_ready, 32'h0);
            tick();
            check("stall_out_data", out_data, 32'd30);
            check("stall_out_chan", 32'(out_chan), 32'd30);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 32'h0000_0008);
        tick();
        check("release_out_chan", 32'(out_chan), 32'd3);
        check("release_out_valid", 32'(out_valid), 32'd1);

        // Reset while stalled with a word held
        out_ready = 1'b0; rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 32'h0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'h0);
        rst = 1'b0; in_valid = '1; out_ready = 1'b1; mode = 1'b1;
        #1;
        check("postrst_in_ready", in_ready, 32'h1);
        tick();
        check("postrst_out_chan", 32'(out_chan), 32'd0);

        // Mode-0 transfer leaves the pointer alone; round-robin resumes after channel 0
        mode = 1'b0; s = 5'd9;
        #1;
        check("m0_in_ready", in_ready, 32'h1 << 9);
        tick();
        check("m0_out_chan", 32'(out_chan), 32'd9);
        mode = 1'b1;
        #1;
        check("resume_in_ready", in_ready, 32'h2);
        tick();
        check("resume_out_chan", 32'(out_chan), 32'd1);

        // Select change while stalled must not disturb the held word
        out_ready = 1'b0; mode = 1'b0; s = 5'd12;
        tick();
        check("selchg_out_chan", 32'(out_chan), 32'd1);
        check("selchg_out_data", out_data, 32'd1);
        out_ready = 1'b1;
        #1;
        check("selchg_in_ready", in_ready, 32'h1 << 12);
        tick();
        check("selchg_new_chan", 32'(out_chan), 32'd12);

`ifdef STREAM_MUX_XFER_COUNT_EN
        rst = 1'b1; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("xfer_count_10", xfer_count, 32'd10);
        rst = 1'b1;
        tick();
        check("xfer_count_rst", xfer_count, 32'd0);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
